// File: rtl/axil_read_arbiter.sv
// axil_read_arbiter: two-to-one AXI-lite read arbiter. It shares one memory read
// port between the instruction-fetch and data-load requesters, with one
// transaction outstanding at a time.
// The winning address is registered toward memory. The response path is a
// combinational pass-through to the granted requester.
// Optional macro AXIL_ARB_FIXED_PRIO_EN selects fixed priority, where the
// instruction requester always wins a tie. When the macro is undefined, the
// arbiter uses round-robin between the two requesters.
module axil_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_ARADDR,
    input  logic              i_ARVALID,
    output logic              i_ARREADY,
    output logic [DATA_W-1:0] i_RDATA,
    output logic              i_RVALID,
    input  logic              i_RREADY,
    input  logic [ADDR_W-1:0] d_ARADDR,
    input  logic              d_ARVALID,
    output logic              d_ARREADY,
    output logic [DATA_W-1:0] d_RDATA,
    output logic              d_RVALID,
    input  logic              d_RREADY,
    output logic [ADDR_W-1:0] mem_ARADDR,
    output logic              mem_ARVALID,
    input  logic              mem_ARREADY,
    input  logic [DATA_W-1:0] mem_RDATA,
    input  logic              mem_RVALID,
    output logic              mem_RREADY,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;     // 0 = instr, 1 = data
    logic                last_q, last_d;   // requester granted last
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                win_s;            // 0 = instr wins, 1 = data wins
    logic                mem_rready_s;

`ifdef AXIL_ARB_FIXED_PRIO_EN
    // Pick the winner: the instruction requester always has priority.
    always_comb begin
        win_s = 1'b0;
        if (i_ARVALID) begin
            win_s = 1'b0;
        end else if (d_ARVALID) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end
`else
    // Pick the winner: on a tie, the requester that was not granted last wins.
    always_comb begin
        win_s = 1'b0;
        if (i_ARVALID && d_ARVALID) begin
            win_s = ~last_q;
        end else if (d_ARVALID) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end
`endif

    // Compute the next state and the combinational handshake and response routing.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        addr_d       = addr_q;
        i_ARREADY    = 1'b0;
        d_ARREADY    = 1'b0;
        i_RVALID     = 1'b0;
        d_RVALID     = 1'b0;
        mem_rready_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_ARVALID || d_ARVALID) begin
                    gnt_d     = win_s;
                    addr_d    = win_s ? d_ARADDR : i_ARADDR;
                    i_ARREADY = ~win_s;
                    d_ARREADY = win_s;
                    state_d   = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (mem_ARREADY) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                mem_rready_s = gnt_q ? d_RREADY : i_RREADY;
                i_RVALID     = ~gnt_q & mem_RVALID;
                d_RVALID     = gnt_q & mem_RVALID;
                if (mem_RVALID && mem_rready_s) begin
                    last_d  = gnt_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant, round-robin history and the captured address register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
        end
    end

    assign mem_ARADDR  = addr_q;
    assign mem_ARVALID = (state_q == ST_ADDR);
    assign mem_RREADY  = mem_rready_s;
    assign busy        = (state_q != ST_IDLE);
    assign i_RDATA     = mem_RDATA;
    assign d_RDATA     = mem_RDATA;

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Directed testbench for axil_read_arbiter. Expected grants, addresses and data
// are queued when requests are driven and popped as each transaction completes.
module tb_axil_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_ARADDR, d_ARADDR, mem_ARADDR, mem_RDATA;
    logic [31:0] i_RDATA, d_RDATA;
    logic        i_ARVALID, i_ARREADY, i_RVALID, i_RREADY;
    logic        d_ARVALID, d_ARREADY, d_RVALID, d_RREADY;
    logic        mem_ARVALID, mem_ARREADY, mem_RVALID, mem_RREADY, busy;

    typedef struct {
        logic        gnt;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    axil_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_ARADDR(i_ARADDR), .i_ARVALID(i_ARVALID), .i_ARREADY(i_ARREADY),
        .i_RDATA(i_RDATA), .i_RVALID(i_RVALID), .i_RREADY(i_RREADY),
        .d_ARADDR(d_ARADDR), .d_ARVALID(d_ARVALID), .d_ARREADY(d_ARREADY),
        .d_RDATA(d_RDATA), .d_RVALID(d_RVALID), .d_RREADY(d_RREADY),
        .mem_ARADDR(mem_ARADDR), .mem_ARVALID(mem_ARVALID), .mem_ARREADY(mem_ARREADY),
        .mem_RDATA(mem_RDATA), .mem_RVALID(mem_RVALID), .mem_RREADY(mem_RREADY),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic push(input logic g, input logic [31:0] a);
        exp_t e;
        e.gnt  = g;
        e.addr = a;
        e.data = mem_model(a);
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Run one transaction from the IDLE cycle (requests already driven at a negedge).
    task automatic run_txn(input int ar_stall, input int r_stall, input bit drop);
        exp_t e;
        chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        #1;
        chk("busy_idle", 64'(busy), 64'd0);
        chk("i_arready", 64'(i_ARREADY), 64'(!e.gnt));
        chk("d_arready", 64'(d_ARREADY), 64'(e.gnt));
        @(posedge clk);
        @(negedge clk);
        if (drop) begin
            if (e.gnt) d_ARVALID = 1'b0;
            else       i_ARVALID = 1'b0;
        end
        mem_ARREADY = 1'b0;
        for (int k = 0; k < ar_stall; k++) begin
            #1;
            chk("stall_arvalid", 64'(mem_ARVALID), 64'd1);
            chk("stall_araddr", 64'(mem_ARADDR), 64'(e.addr));
            chk("stall_no_arready", 64'({i_ARREADY, d_ARREADY}), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        mem_ARREADY = 1'b1;
        #1;
        chk("mem_arvalid", 64'(mem_ARVALID), 64'd1);
        chk("mem_araddr", 64'(mem_ARADDR), 64'(e.addr));
        chk("busy_addr", 64'(busy), 64'd1);
        chk("addr_no_arready", 64'({i_ARREADY, d_ARREADY}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        mem_ARREADY = 1'b0;
        mem_RVALID  = 1'b1;
        mem_RDATA   = e.data;
        if (r_stall > 0) begin
            if (e.gnt) d_RREADY = 1'b0;
            else       i_RREADY = 1'b0;
        end
        for (int k = 0; k < r_stall; k++) begin
            #1;
            chk("bp_mem_rready", 64'(mem_RREADY), 64'd0);
            chk("bp_rvalid", 64'({i_RVALID, d_RVALID}), e.gnt ? 64'd1 : 64'd2);
            chk("bp_busy", 64'(busy), 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        i_RREADY = 1'b1;
        d_RREADY = 1'b1;
        #1;
        chk("rvalid", 64'({i_RVALID, d_RVALID}), e.gnt ? 64'd1 : 64'd2);
        chk("i_rdata", 64'(i_RDATA), 64'(e.data));
        chk("d_rdata", 64'(d_RDATA), 64'(e.data));
        chk("mem_rready", 64'(mem_RREADY), 64'd1);
        @(posedge clk);
        @(negedge clk);
        mem_RVALID = 1'b0;
        mem_RDATA  = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        i_ARADDR = 32'h0; i_ARVALID = 1'b0; i_RREADY = 1'b1;
        d_ARADDR = 32'h0; d_ARVALID = 1'b0; d_RREADY = 1'b1;
        mem_ARREADY = 1'b0; mem_RVALID = 1'b0; mem_RDATA = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state, with a stray memory response that must be ignored in IDLE.
        mem_RVALID = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_arvalid", 64'(mem_ARVALID), 64'd0);
        chk("rst_mem_araddr", 64'(mem_ARADDR), 64'd0);
        chk("rst_mem_rready", 64'(mem_RREADY), 64'd0);
        chk("rst_rvalid", 64'({i_RVALID, d_RVALID}), 64'd0);
        chk("rst_arready", 64'({i_ARREADY, d_ARREADY}), 64'd0);
        @(negedge clk);
        mem_RVALID = 1'b0;

        // Single instruction read of 0x10.
        push(1'b0, 32'h10);
        i_ARADDR = 32'h10; i_ARVALID = 1'b1;
        run_txn(0, 0, 1'b1);

        // Simultaneous held requests from reset.
        do_reset();
        i_ARADDR = 32'h4; d_ARADDR = 32'h8;
        i_ARVALID = 1'b1; d_ARVALID = 1'b1;
`ifdef AXIL_ARB_FIXED_PRIO_EN
        for (int n = 0; n < 4; n++) push(1'b0, 32'h4);
`else
        for (int n = 0; n < 4; n++) push(n[0], n[0] ? 32'h8 : 32'h4);
`endif
        for (int n = 0; n < 4; n++) run_txn(0, 0, 1'b0);
        i_ARVALID = 1'b0; d_ARVALID = 1'b0;

        // Memory address stall of 5 cycles on a data read.
        push(1'b1, 32'h20);
        d_ARADDR = 32'h20; d_ARVALID = 1'b1;
        run_txn(5, 0, 1'b1);

        // Data requester backpressure for 3 cycles.
        push(1'b1, 32'h24);
        d_ARADDR = 32'h24; d_ARVALID = 1'b1;
        run_txn(0, 3, 1'b1);

        // Instruction read so that the instruction requester becomes the last grant.
        push(1'b0, 32'h30);
        i_ARADDR = 32'h30; i_ARVALID = 1'b1;
        run_txn(0, 0, 1'b1);

        // Data read interrupted by reset while in DATA.
        d_ARADDR = 32'h40; d_ARVALID = 1'b1;
        #1;
        chk("mid_d_arready", 64'(d_ARREADY), 64'd1);
        @(posedge clk);
        @(negedge clk);
        d_ARVALID = 1'b0;
        mem_ARREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ARREADY = 1'b0;
        mem_RVALID = 1'b1; mem_RDATA = 32'h1234_5678; d_RREADY = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_d_rvalid", 64'(d_RVALID), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        d_RREADY = 1'b1;
        #1;
        chk("postrst_busy", 64'(busy), 64'd0);
        chk("postrst_rvalid", 64'({i_RVALID, d_RVALID}), 64'd0);
        chk("postrst_mem_rready", 64'(mem_RREADY), 64'd0);
        chk("postrst_mem_arvalid", 64'(mem_ARVALID), 64'd0);
        chk("postrst_mem_araddr", 64'(mem_ARADDR), 64'd0);
        @(negedge clk);
        mem_RVALID = 1'b0; mem_RDATA = 32'h0;

        // Tie after reset: instruction wins first, then the other requester.
        i_ARADDR = 32'h50; d_ARADDR = 32'h54;
        i_ARVALID = 1'b1; d_ARVALID = 1'b1;
        push(1'b0, 32'h50);
`ifdef AXIL_ARB_FIXED_PRIO_EN
        push(1'b0, 32'h50);
`else
        push(1'b1, 32'h54);
`endif
        run_txn(0, 0, 1'b0);
        run_txn(0, 0, 1'b0);
        i_ARVALID = 1'b0; d_ARVALID = 1'b0;

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
